// File: rtl/rr_write_buf_sequencer_if.sv
// Bundle of signals between the host/storage-writer side and the sequencer.
//   cfg_*            : descriptor programming port (host -> sequencer)
//   start/stop       : level controls (host -> sequencer)
//   write_interrupt,
//   record_bits      : status from the storage writer
//   write_buf_*      : buffer load to the storage writer
//   done_*           : buffer-retired event
//   desc_valid, cur_idx, stalled, stall_cnt, cfg_err : status
// master = host/writer side, slave = sequencer.
interface rr_write_buf_sequencer_if #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int NBUF           = 4,
  parameter int IDX_W          = $clog2(NBUF)
);
  logic                      cfg_wr_en;
  logic [IDX_W-1:0]          cfg_idx;
  logic [AXI_ADDR_WIDTH-1:0] cfg_addr;
  logic [AXI_ADDR_WIDTH-1:0] cfg_size;
  logic                      start;
  logic                      stop;
  logic                      write_interrupt;
  logic [63:0]               record_bits;
  logic [AXI_ADDR_WIDTH-1:0] write_buf_addr;
  logic [AXI_ADDR_WIDTH-1:0] write_buf_size;
  logic                      write_buf_update;
  logic                      done_valid;
  logic [IDX_W-1:0]          done_idx;
  logic [63:0]               done_bits;
  logic                      done_partial;
  logic [NBUF-1:0]           desc_valid;
  logic [IDX_W-1:0]          cur_idx;
  logic                      stalled;
  logic [31:0]               stall_cnt;
  logic                      cfg_err;

  modport master (
    output cfg_wr_en, cfg_idx, cfg_addr, cfg_size, start, stop,
           write_interrupt, record_bits,
    input  write_buf_addr, write_buf_size, write_buf_update,
           done_valid, done_idx, done_bits, done_partial,
           desc_valid, cur_idx, stalled, stall_cnt, cfg_err
  );

  modport slave (
    input  cfg_wr_en, cfg_idx, cfg_addr, cfg_size, start, stop,
           write_interrupt, record_bits,
    output write_buf_addr, write_buf_size, write_buf_update,
           done_valid, done_idx, done_bits, done_partial,
           desc_valid, cur_idx, stalled, stall_cnt, cfg_err
  );
endinterface

// File: rtl/rr_write_buf_sequencer.sv
// Round-robin sequencer handing a ring of host buffer descriptors to a
// storage writer. Software owns a descriptor until it writes it (valid bit
// set); hardware hands it to the writer, waits for "full" or stop, retires it
// (done event, valid bit cleared) and moves to the next slot.
// Ports: clk, rst (async, active-high), bus (slave side of the interface).
module rr_write_buf_sequencer #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int NBUF           = 4,
  parameter int IDX_W          = $clog2(NBUF)
) (
  input logic                    clk,
  input logic                    rst,
  rr_write_buf_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ARM, SETTLE, FILL, STALL, DONE} state_t;

  state_t state, state_nxt;

  logic [NBUF-1:0][AXI_ADDR_WIDTH-1:0] desc_addr, desc_size;
  logic [NBUF-1:0]                     desc_valid;
  logic [IDX_W-1:0]                    cur_idx, idx_nxt, idx_inc;
  logic                                settle_cnt;
  logic                                retire, retire_partial;
  logic [AXI_ADDR_WIDTH-1:0]           buf_addr, buf_size;
  logic                                done_valid, done_partial;
  logic [IDX_W-1:0]                    done_idx;
  logic [63:0]                         done_bits;
  logic [31:0]                         stall_cnt;
  logic                                cfg_err;

  // NBUF is a power of two, so the natural wrap of the adder is the ring wrap.
  assign idx_inc = cur_idx + IDX_W'(1);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state; also decides the retirement and the next target index
  always_comb begin
    state_nxt      = state;
    idx_nxt        = cur_idx;
    retire         = 1'b0;
    retire_partial = 1'b0;
    case (state)
      IDLE, DONE:
        if (bus.start) begin
          idx_nxt   = '0;
          state_nxt = desc_valid[0] ? ARM : STALL;
        end
      ARM:    state_nxt = SETTLE;
      // write_interrupt is stale for two cycles after a load; ignore it here.
      SETTLE: if (settle_cnt) state_nxt = FILL;
      FILL:
        if (bus.write_interrupt) begin
          // full wins over stop when both arrive together
          retire  = 1'b1;
          idx_nxt = idx_inc;
          if (bus.stop)                 state_nxt = DONE;
          else if (desc_valid[idx_inc]) state_nxt = ARM;
          else                          state_nxt = STALL;
        end else if (bus.stop) begin
          retire         = 1'b1;
          retire_partial = 1'b1;
          state_nxt      = DONE;
        end
      STALL:
        if (bus.stop)                 state_nxt = DONE;
        else if (desc_valid[cur_idx]) state_nxt = ARM;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    bus.write_buf_update = (state == ARM);
    bus.stalled          = (state == STALL);
  end

  // datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_idx      <= '0;
      settle_cnt   <= 1'b0;
      buf_addr     <= '0;
      buf_size     <= '0;
      done_valid   <= 1'b0;
      done_idx     <= '0;
      done_bits    <= '0;
      done_partial <= 1'b0;
      stall_cnt    <= '0;
      cfg_err      <= 1'b0;
      desc_valid   <= '0;
      desc_addr    <= '0;
      desc_size    <= '0;
    end else begin
      cur_idx    <= idx_nxt;
      settle_cnt <= (state == SETTLE) && !settle_cnt;

      // Latch the buffer on the edge into ARM so addr/size are already valid
      // in the update cycle and hold until the next ARM.
      if (state_nxt == ARM) begin
        buf_addr <= desc_addr[idx_nxt];
        buf_size <= desc_size[idx_nxt];
      end

      done_valid <= retire;
      if (retire) begin
        done_idx     <= cur_idx;
        done_bits    <= bus.record_bits;
        done_partial <= retire_partial;
      end

      if (state == STALL && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;

      // A write landing on the slot being retired this cycle is accepted:
      // the retirement frees the slot first.
      if (bus.cfg_wr_en && desc_valid[bus.cfg_idx] &&
          !(retire && bus.cfg_idx == cur_idx))
        cfg_err <= 1'b1;

      for (int i = 0; i < NBUF; i++) begin
        if (bus.cfg_wr_en && bus.cfg_idx == IDX_W'(i) &&
            (!desc_valid[i] || (retire && cur_idx == IDX_W'(i)))) begin
          desc_valid[i] <= 1'b1;
          desc_addr[i]  <= bus.cfg_addr;
          desc_size[i]  <= bus.cfg_size;
        end else if (retire && cur_idx == IDX_W'(i)) begin
          desc_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.write_buf_addr = buf_addr;
  assign bus.write_buf_size = buf_size;
  assign bus.done_valid     = done_valid;
  assign bus.done_idx       = done_idx;
  assign bus.done_bits      = done_bits;
  assign bus.done_partial   = done_partial;
  assign bus.desc_valid     = desc_valid;
  assign bus.cur_idx        = cur_idx;
  assign bus.stall_cnt      = stall_cnt;
  assign bus.cfg_err        = cfg_err;
endmodule

// File: tb/tb_rr_write_buf_sequencer.sv
module tb_rr_write_buf_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  rr_write_buf_sequencer_if bus();

  rr_write_buf_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // all DUT outputs are registered or state-decoded, so sampling 1 unit
  // after the edge sees settled values
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [63:0] a, input logic [63:0] sz);
    bus.cfg_wr_en = 1'b1;
    bus.cfg_idx   = idx;
    bus.cfg_addr  = a;
    bus.cfg_size  = sz;
    tick();
    bus.cfg_wr_en = 1'b0;
  endtask

  task automatic retire_full(input logic [63:0] bits);
    bus.write_interrupt = 1'b1;
    bus.record_bits     = bits;
    tick();
    bus.write_interrupt = 1'b0;
  endtask

  task automatic to_fill();  // ARM -> SETTLE -> SETTLE -> FILL
    tick(); tick(); tick();
  endtask

  initial begin
    bus.cfg_wr_en = 1'b0; bus.cfg_idx = '0; bus.cfg_addr = '0; bus.cfg_size = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.write_interrupt = 1'b0; bus.record_bits = '0;

    // reset state
    #3;
    chk("rst_upd", bus.write_buf_update, 0);
    chk("rst_addr", bus.write_buf_addr, 0);
    chk("rst_dv", bus.done_valid, 0);
    chk("rst_desc", bus.desc_valid, 0);
    chk("rst_stall", bus.stalled, 0);
    chk("rst_cnt", bus.stall_cnt, 0);
    tick(); tick();
    rst = 1'b0;

    // basic load / fill / retire
    cfg_write(0, 64'h1000, 64'h40);
    cfg_write(1, 64'h2000, 64'h40);
    chk("ld_desc", bus.desc_valid, 4'b0011);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("a0_upd", bus.write_buf_update, 1);
    chk("a0_addr", bus.write_buf_addr, 64'h1000);
    chk("a0_size", bus.write_buf_size, 64'h40);
    chk("a0_cur", bus.cur_idx, 0);
    tick();
    chk("s0_upd", bus.write_buf_update, 0);
    tick(); tick();
    retire_full(64'd300);
    chk("r0_dv", bus.done_valid, 1);
    chk("r0_idx", bus.done_idx, 0);
    chk("r0_bits", bus.done_bits, 64'd300);
    chk("r0_part", bus.done_partial, 0);
    chk("a1_upd", bus.write_buf_update, 1);
    chk("a1_addr", bus.write_buf_addr, 64'h2000);
    chk("a1_cur", bus.cur_idx, 1);
    chk("r0_desc", bus.desc_valid, 4'b0010);

    // ring wrap with desc0 refilled
    cfg_write(2, 64'h3000, 64'h40);
    chk("r0_pulse", bus.done_valid, 0);
    cfg_write(3, 64'h4000, 64'h40);
    tick();
    retire_full(64'd400);
    chk("r1_idx", bus.done_idx, 1);
    chk("a2_addr", bus.write_buf_addr, 64'h3000);
    to_fill();
    retire_full(64'd500);
    chk("r2_idx", bus.done_idx, 2);
    chk("a3_addr", bus.write_buf_addr, 64'h4000);
    chk("a3_cur", bus.cur_idx, 3);
    cfg_write(0, 64'h5000, 64'h80);
    tick(); tick();
    retire_full(64'd600);
    chk("r3_idx", bus.done_idx, 3);
    chk("wrap_cur", bus.cur_idx, 0);
    chk("wrap_upd", bus.write_buf_update, 1);
    chk("wrap_addr", bus.write_buf_addr, 64'h5000);
    chk("wrap_size", bus.write_buf_size, 64'h80);
    chk("wrap_desc", bus.desc_valid, 4'b0001);

    // stall on missing desc1
    to_fill();
    retire_full(64'd700);
    chk("st_dv", bus.done_valid, 1);
    chk("st_stall", bus.stalled, 1);
    chk("st_upd", bus.write_buf_update, 0);
    chk("st_cur", bus.cur_idx, 1);
    chk("st_cnt0", bus.stall_cnt, 0);
    repeat (8) tick();
    cfg_write(1, 64'h6000, 64'h40);
    chk("st_still", bus.stalled, 1);
    chk("st_cnt9", bus.stall_cnt, 9);
    tick();
    chk("st_arm", bus.write_buf_update, 1);
    chk("st_addr", bus.write_buf_addr, 64'h6000);
    chk("st_out", bus.stalled, 0);
    chk("st_cnt10", bus.stall_cnt, 10);

    // stop during FILL -> partial retirement, DONE
    to_fill();
    bus.stop = 1'b1; bus.record_bits = 64'd96; tick(); bus.stop = 1'b0;
    chk("sp_dv", bus.done_valid, 1);
    chk("sp_part", bus.done_partial, 1);
    chk("sp_bits", bus.done_bits, 64'd96);
    chk("sp_idx", bus.done_idx, 1);
    chk("sp_cur", bus.cur_idx, 1);
    chk("sp_desc", bus.desc_valid, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sp_noupd", bus.write_buf_update, 0);
    end
    chk("sp_nostall", bus.stalled, 0);
    chk("sp_cnt", bus.stall_cnt, 10);

    // interrupt held through SETTLE
    cfg_write(0, 64'h7000, 64'h40);
    cfg_write(1, 64'h8000, 64'h40);
    bus.write_interrupt = 1'b1; bus.record_bits = 64'd1234;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("hi_upd", bus.write_buf_update, 1);
    chk("hi_addr", bus.write_buf_addr, 64'h7000);
    chk("hi_dv_arm", bus.done_valid, 0);
    tick(); chk("hi_dv_s1", bus.done_valid, 0);
    tick(); chk("hi_dv_s2", bus.done_valid, 0);
    tick(); chk("hi_dv_fill", bus.done_valid, 0);
    tick(); bus.write_interrupt = 1'b0;
    chk("hi_dv", bus.done_valid, 1);
    chk("hi_bits", bus.done_bits, 64'd1234);
    chk("hi_addr1", bus.write_buf_addr, 64'h8000);

    // write to the slot being retired in the same cycle is accepted
    to_fill();
    bus.write_interrupt = 1'b1; bus.record_bits = 64'd5;
    bus.cfg_wr_en = 1'b1; bus.cfg_idx = 2'd1; bus.cfg_addr = 64'hA000; bus.cfg_size = 64'h40;
    tick();
    bus.write_interrupt = 1'b0; bus.cfg_wr_en = 1'b0;
    chk("co_dv", bus.done_idx, 1);
    chk("co_desc", bus.desc_valid, 4'b0010);
    chk("co_err", bus.cfg_err, 0);
    chk("co_stall", bus.stalled, 1);
    chk("co_cur", bus.cur_idx, 2);
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    chk("sst_stall", bus.stalled, 0);
    chk("sst_dv", bus.done_valid, 0);

    // write to a valid descriptor is dropped
    cfg_write(1, 64'hB000, 64'h40);
    chk("err_set", bus.cfg_err, 1);
    chk("err_desc", bus.desc_valid, 4'b0010);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("err_stall", bus.stalled, 1);
    chk("err_cur", bus.cur_idx, 0);
    cfg_write(0, 64'hC000, 64'h40);
    tick();
    chk("err_a0", bus.write_buf_addr, 64'hC000);
    to_fill();
    retire_full(64'd77);
    chk("err_bits", bus.done_bits, 64'd77);
    chk("err_keep", bus.write_buf_addr, 64'hA000);
    chk("err_cur1", bus.cur_idx, 1);

    // reset mid-FILL
    to_fill();
    bus.write_interrupt = 1'b1; bus.record_bits = 64'd55;
    #2 rst = 1'b1;
    #1;
    chk("ar_upd", bus.write_buf_update, 0);
    chk("ar_addr", bus.write_buf_addr, 0);
    chk("ar_size", bus.write_buf_size, 0);
    chk("ar_dv", bus.done_valid, 0);
    chk("ar_bits", bus.done_bits, 0);
    chk("ar_desc", bus.desc_valid, 0);
    chk("ar_cur", bus.cur_idx, 0);
    chk("ar_cnt", bus.stall_cnt, 0);
    chk("ar_err", bus.cfg_err, 0);
    tick();
    chk("ar_dv_edge", bus.done_valid, 0);
    bus.write_interrupt = 1'b0;
    rst = 1'b0;
    tick();
    chk("ar_dv_rel", bus.done_valid, 0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("ar_restall", bus.stalled, 1);
    chk("ar_noupd", bus.write_buf_update, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
